vga_layer_compositor: RTL

- Parametrised N-layer sprite compositor for the VGA path.
- Each layer has a runtime-configurable screen rectangle, ROM x/y offset (tile/glyph select), enable and transparency flag.
- Drives per-layer sprite ROM addresses, aligns hit flags to ROM read latency, and resolves a priority-ordered, transparency-aware pixel colour.
- Sits between the VGA timing generator (xvga/yvga) and the VGA DAC colour input. Replaces fixed-rectangle, two-source combining.

---
 rtl/vga_layer_compositor_if.sv | 51 +++++
 rtl/vga_layer_compositor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/vga_layer_compositor_if.sv
// Pixel/config/ROM bus between the VGA timing side and the layer compositor.
//   master : timing generator + config writer + sprite ROMs (drives pixel coords,
//            config strobes and ROM data; receives ROM addresses and colour)
//   slave  : vga_layer_compositor
// Signals:
//   xvga, yvga            current pixel coordinate
//   frame_start           commit pulse for shadow config
//   cfg_*                 shadow config write port (one layer per write)
//   rom_x, rom_y          flattened per-layer ROM addresses
//   rom_dout              flattened per-layer ROM data, ROM_LATENCY cycles behind address
//   color                 composited, registered pixel colour
interface vga_layer_compositor_if #(
  parameter int unsigned NUM_LAYERS = 4,
  parameter int unsigned X_W        = 8,
  parameter int unsigned Y_W        = 7,
  parameter int unsigned ROM_X_W    = 10,
  parameter int unsigned ROM_Y_W    = 7,
  parameter int unsigned COLOR_W    = 3
);
  localparam int unsigned LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic [X_W-1:0]                xvga;
  logic [Y_W-1:0]                yvga;
  logic                          frame_start;
  logic                          cfg_we;
  logic [LAYER_W-1:0]            cfg_layer;
  logic [X_W-1:0]                cfg_pos_x;
  logic [Y_W-1:0]                cfg_pos_y;
  logic [X_W-1:0]                cfg_w;
  logic [Y_W-1:0]                cfg_h;
  logic [ROM_X_W-1:0]            cfg_off_x;
  logic [ROM_Y_W-1:0]            cfg_off_y;
  logic                          cfg_en;
  logic                          cfg_transp_en;
  logic [NUM_LAYERS*ROM_X_W-1:0] rom_x;
  logic [NUM_LAYERS*ROM_Y_W-1:0] rom_y;
  logic [NUM_LAYERS*COLOR_W-1:0] rom_dout;
  logic [COLOR_W-1:0]            color;

  modport master (
    output xvga, yvga, frame_start, cfg_we, cfg_layer, cfg_pos_x, cfg_pos_y, cfg_w, cfg_h,
           cfg_off_x, cfg_off_y, cfg_en, cfg_transp_en, rom_dout,
    input  rom_x, rom_y, color
  );

  modport slave (
    input  xvga, yvga, frame_start, cfg_we, cfg_layer, cfg_pos_x, cfg_pos_y, cfg_w, cfg_h,
           cfg_off_x, cfg_off_y, cfg_en, cfg_transp_en, rom_dout,
    output rom_x, rom_y, color
  );
endinterface

// File: rtl/vga_layer_compositor.sv
// N-layer sprite compositor for the VGA pixel path.
// Each layer has a shadow and an active config bank; frame_start copies shadow to
// active. Per pixel, every layer computes a rectangle hit and a ROM address; hit and
// transparency flags are delayed to line up with rom_dout, then the lowest-index
// opaque layer supplies the registered output colour (BG_COLOR if none).
// Ports:
//   VGA_CLK  pixel clock, rising edge
//   reset    asynchronous active-high reset
//   bus      vga_layer_compositor_if slave (pixel coords, config, ROM bus, colour)
// Latency xvga/yvga -> color is ROM_LATENCY+1 cycles, one pixel per clock.
module vga_layer_compositor #(
  parameter int unsigned NUM_LAYERS   = 4,
  parameter int unsigned X_W          = 8,
  parameter int unsigned Y_W          = 7,
  parameter int unsigned ROM_X_W      = 10,
  parameter int unsigned ROM_Y_W      = 7,
  parameter int unsigned COLOR_W      = 3,
  parameter int unsigned ROM_LATENCY  = 1,
  parameter int unsigned TRANSP_COLOR = 0,
  parameter int unsigned BG_COLOR     = 0
) (
  input logic                   VGA_CLK,
  input logic                   reset,
  vga_layer_compositor_if.slave bus
);
  localparam int unsigned LAYER_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  typedef struct packed {
    logic [X_W-1:0]     pos_x;
    logic [Y_W-1:0]     pos_y;
    logic [X_W-1:0]     w;
    logic [Y_W-1:0]     h;
    logic [ROM_X_W-1:0] off_x;
    logic [ROM_Y_W-1:0] off_y;
    logic               en;
    logic               transp_en;
  } layer_cfg_t;

  layer_cfg_t            shadow_q [NUM_LAYERS];
  layer_cfg_t            active_q [NUM_LAYERS];
  layer_cfg_t            cfg_wdata;
  logic [NUM_LAYERS-1:0] cfg_sel;

  // Out-of-range cfg_layer matches no index, so the write is dropped.
  always_comb begin
    cfg_wdata.pos_x     = bus.cfg_pos_x;
    cfg_wdata.pos_y     = bus.cfg_pos_y;
    cfg_wdata.w         = bus.cfg_w;
    cfg_wdata.h         = bus.cfg_h;
    cfg_wdata.off_x     = bus.cfg_off_x;
    cfg_wdata.off_y     = bus.cfg_off_y;
    cfg_wdata.en        = bus.cfg_en;
    cfg_wdata.transp_en = bus.cfg_transp_en;
    cfg_sel             = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      cfg_sel[i] = bus.cfg_we && (bus.cfg_layer == LAYER_W'(i));
    end
  end

  // A write in the commit cycle goes straight through to the active bank.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (cfg_sel[i]) begin
          shadow_q[i] <= cfg_wdata;
        end
        if (bus.frame_start) begin
          active_q[i] <= cfg_sel[i] ? cfg_wdata : shadow_q[i];
        end
      end
    end
  end

  logic [NUM_LAYERS-1:0] hit;
  logic [NUM_LAYERS-1:0] transp_en;
  logic [COLOR_W-1:0]    layer_dout [NUM_LAYERS];

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
    logic [X_W:0]   x_end;
    logic [Y_W:0]   y_end;
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;

    // One extra bit so pos+size never wraps back onto the left/top of the screen.
    assign x_end = {1'b0, active_q[g].pos_x} + {1'b0, active_q[g].w};
    assign y_end = {1'b0, active_q[g].pos_y} + {1'b0, active_q[g].h};
    assign dx    = bus.xvga - active_q[g].pos_x;
    assign dy    = bus.yvga - active_q[g].pos_y;

    assign hit[g] = active_q[g].en
                    && (bus.xvga >= active_q[g].pos_x) && ({1'b0, bus.xvga} < x_end)
                    && (bus.yvga >= active_q[g].pos_y) && ({1'b0, bus.yvga} < y_end);
    assign transp_en[g] = active_q[g].transp_en;

    assign bus.rom_x[g*ROM_X_W +: ROM_X_W] = ROM_X_W'(dx) + active_q[g].off_x;
    assign bus.rom_y[g*ROM_Y_W +: ROM_Y_W] = ROM_Y_W'(dy) + active_q[g].off_y;
    assign layer_dout[g] = bus.rom_dout[g*COLOR_W +: COLOR_W];
  end

  // Flags ride alongside the ROM read so they meet rom_dout in the same cycle.
  logic [NUM_LAYERS-1:0] hit_pipe_q    [ROM_LATENCY];
  logic [NUM_LAYERS-1:0] transp_pipe_q [ROM_LATENCY];

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < ROM_LATENCY; s++) begin
        hit_pipe_q[s]    <= '0;
        transp_pipe_q[s] <= '0;
      end
    end else begin
      hit_pipe_q[0]    <= hit;
      transp_pipe_q[0] <= transp_en;
      for (int s = 1; s < ROM_LATENCY; s++) begin
        hit_pipe_q[s]    <= hit_pipe_q[s-1];
        transp_pipe_q[s] <= transp_pipe_q[s-1];
      end
    end
  end

  logic [NUM_LAYERS-1:0] opaque;
  logic [COLOR_W-1:0]    color_d;
  logic [COLOR_W-1:0]    color_q;

  always_comb begin
    opaque = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      opaque[i] = hit_pipe_q[ROM_LATENCY-1][i]
                  && !(transp_pipe_q[ROM_LATENCY-1][i]
                       && (layer_dout[i] == COLOR_W'(TRANSP_COLOR)));
    end
  end

  // Scan from lowest priority up so the lowest opaque index is the last to win.
  always_comb begin
    color_d = COLOR_W'(BG_COLOR);
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        color_d = layer_dout[i];
      end
    end
  end

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      color_q <= COLOR_W'(BG_COLOR);
    end else begin
      color_q <= color_d;
    end
  end

  assign bus.color = color_q;

endmodule
